// File: rtl/serial_config_sequencer_pkg.sv
// rtl/serial_config_sequencer_pkg.sv - sequencer states, gain/frame widths and frame builder (SER_PARITY_EN)
package serial_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    WAIT_RDY,
    SHIFT,
    SETTLE,
    MONITOR,
    DONE,
    ERR
  } state_e;

  localparam int GAINA1_W = 3;
  localparam int GAINA2_W = 2;

`ifdef SER_PARITY_EN
  localparam int FRAME_W = 9;
`else
  localparam int FRAME_W = 8;
`endif

  localparam int BIT_IDX_W = $clog2(FRAME_W);

  // Frame is sent MSB-first; the parity bit, when present, goes out last.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [GAINA1_W-1:0] gain_a1,
                                                     input logic [GAINA2_W-1:0] gain_a2);
    logic [7:0] base;
    base = {gain_a1, gain_a2, 3'b000};
`ifdef SER_PARITY_EN
    return {base, ~^base};
`else
    return base;
`endif
  endfunction

endpackage

// File: rtl/serial_config_sequencer_sclk_phase_gen.sv
// rtl/serial_config_sequencer_sclk_phase_gen.sv - sclk divider: rise strobe at end of low phase, bit_done at end of high phase
module sclk_phase_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_rise_en,
  output logic o_bit_done
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign o_rise_en  = i_en && (div_q == DIV_W'(HALF - 1));
  assign o_bit_done = i_en && (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d = div_q + 1'b1;
    if (!i_en || o_bit_done) begin
      div_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/serial_config_sequencer.sv
// rtl/serial_config_sequencer.sv - backend bring-up: reset hold, ready wait, gain frame shift, VCO1-fast monitor.
// Frame width and odd parity bit selected by SER_PARITY_EN.
module serial_config_sequencer
  import serial_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYC    = 8,
  parameter int READY_TO   = 64,
  parameter int SETTLE_CYC = 16,
  parameter int MON_CYC    = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [GAINA1_W-1:0] i_cfg_gainA1,
  input  logic [GAINA2_W-1:0] i_cfg_gainA2,
  input  logic                i_ready,
  input  logic                i_vco1_fast,
  output logic                o_resetbAll,
  output logic                o_sclk,
  output logic                o_sdout,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic                o_vco1_fast_seen
);

  localparam int MAX_A = (RST_CYC > READY_TO) ? RST_CYC : READY_TO;
  localparam int MAX_B = (SETTLE_CYC > MON_CYC) ? SETTLE_CYC : MON_CYC;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_inc;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic [BIT_IDX_W-1:0] next_idx;
  logic [FRAME_W-1:0]   frame_q;
  logic                 started_q;
  logic                 vco_meta_q;
  logic                 vco_sync_q;
  logic                 rise_en;
  logic                 bit_done;

  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign next_idx = bit_idx_q - 1'b1;

  sclk_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_phase (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (state_q == SHIFT),
    .o_rise_en (rise_en),
    .o_bit_done(bit_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      bit_idx_q        <= '0;
      frame_q          <= '0;
      started_q        <= 1'b0;
      vco_meta_q       <= 1'b0;
      vco_sync_q       <= 1'b0;
      o_resetbAll      <= 1'b0;
      o_sclk           <= 1'b0;
      o_sdout          <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      o_vco1_fast_seen <= 1'b0;
    end else begin
      vco_meta_q <= i_vco1_fast;
      vco_sync_q <= vco_meta_q;
      o_done     <= 1'b0;

      case (state_q)
        IDLE: begin
          o_resetbAll <= started_q;
          if (i_start) begin
            state_q          <= RST_HOLD;
            cnt_q            <= '0;
            frame_q          <= build_frame(i_cfg_gainA1, i_cfg_gainA2);
            started_q        <= 1'b1;
            o_resetbAll      <= 1'b0;
            o_busy           <= 1'b1;
            o_error          <= 1'b0;
            o_vco1_fast_seen <= 1'b0;
          end
        end

        RST_HOLD: begin
          if (cnt_q == CNT_W'(RST_CYC - 1)) begin
            state_q     <= WAIT_RDY;
            cnt_q       <= '0;
            o_resetbAll <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        // Ready is checked before the timeout so a late-but-present ready still proceeds.
        WAIT_RDY: begin
          if (i_ready) begin
            state_q   <= SHIFT;
            bit_idx_q <= BIT_IDX_W'(FRAME_W - 1);
            o_sdout   <= frame_q[FRAME_W-1];
            o_sclk    <= 1'b0;
          end else if (cnt_q == CNT_W'(READY_TO - 1)) begin
            state_q <= ERR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        SHIFT: begin
          if (!i_ready) begin
            state_q <= ERR;
            o_sclk  <= 1'b0;
            o_sdout <= 1'b0;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end else if (bit_done) begin
            o_sclk <= 1'b0;
            if (bit_idx_q == '0) begin
              state_q <= SETTLE;
              cnt_q   <= '0;
              o_sdout <= 1'b0;
            end else begin
              bit_idx_q <= next_idx;
              o_sdout   <= frame_q[next_idx];
            end
          end else if (rise_en) begin
            o_sclk <= 1'b1;
          end
        end

        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            state_q <= MONITOR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        MONITOR: begin
          o_vco1_fast_seen <= o_vco1_fast_seen | vco_sync_q;
          if (cnt_q == CNT_W'(MON_CYC - 1)) begin
            state_q <= DONE;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        ERR: begin
          state_q <= IDLE;
          o_sclk  <= 1'b0;
          o_sdout <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_config_sequencer.sv
// tb/tb_serial_config_sequencer.sv - directed bench for serial_config_sequencer (frame constants follow SER_PARITY_EN)
module tb_serial_config_sequencer;

`ifdef SER_PARITY_EN
  localparam int          FW        = 9;
  localparam logic [31:0] FRAME_B0  = 32'h160;
  localparam logic [31:0] FRAME_68  = 32'h0D0;
  localparam logic [31:0] FRAME_D8  = 32'h1B1;
`else
  localparam int          FW        = 8;
  localparam logic [31:0] FRAME_B0  = 32'h0B0;
  localparam logic [31:0] FRAME_68  = 32'h068;
  localparam logic [31:0] FRAME_D8  = 32'h0D8;
`endif
  localparam logic [31:0] FMASK = (32'd1 << FW) - 32'd1;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic [2:0] i_cfg_gainA1;
  logic [1:0] i_cfg_gainA2;
  logic       i_ready;
  logic       i_vco1_fast;
  logic       o_resetbAll;
  logic       o_sclk;
  logic       o_sdout;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic       o_vco1_fast_seen;

  int tests_run;
  int tests_failed;

  int          rises;
  int          done_cnt;
  int          rstb_low;
  logic [31:0] cap;
  logic        sclk_prev;

  serial_config_sequencer dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_cfg_gainA1    (i_cfg_gainA1),
    .i_cfg_gainA2    (i_cfg_gainA2),
    .i_ready         (i_ready),
    .i_vco1_fast     (i_vco1_fast),
    .o_resetbAll     (o_resetbAll),
    .o_sclk          (o_sclk),
    .o_sdout         (o_sdout),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_error         (o_error),
    .o_vco1_fast_seen(o_vco1_fast_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial receiver model: capture sdout on each sclk rise.
  initial begin
    rises = 0; done_cnt = 0; rstb_low = 0; cap = '0; sclk_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (o_sclk && !sclk_prev) begin
      rises = rises + 1;
      cap   = {cap[30:0], o_sdout};
    end
    sclk_prev = o_sclk;
    if (o_done) done_cnt = done_cnt + 1;
    if (!o_resetbAll) rstb_low = rstb_low + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_vec();
    return {25'd0, o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_error, o_vco1_fast_seen};
  endfunction

  // One full sequence; optional VCO pulse mid-monitor and optional stray start during SHIFT.
  task automatic do_run(input logic [2:0] a1, input logic [1:0] a2, input bit pulse_vco,
                        input bit stray_start, output logic seen_o, output int rst_low_n,
                        output int rise_n, output int done_n, output logic [31:0] cap_o);
    int  r0, s0, d0;
    bit  finished;
    r0 = rstb_low; s0 = rises; d0 = done_cnt;
    finished = 1'b0; seen_o = 1'b0;
    i_cfg_gainA1 = a1; i_cfg_gainA2 = a2; i_start = 1'b1; i_ready = 1'b0;
    tick();
    i_start = 1'b0;
    check_eq("run_busy_after_start", 32'(o_busy), 32'd1);
    for (int c = 1; c < 400 && !finished; c++) begin
      if (c == 3) i_ready = 1'b1;
      i_vco1_fast = pulse_vco && (c >= 70) && (c < 73);
      i_start = stray_start && (c == 20);
      i_cfg_gainA1 = (stray_start && c == 20) ? 3'b111 : a1;
      i_cfg_gainA2 = (stray_start && c == 20) ? 2'b11 : a2;
      tick();
      if (o_done) begin
        finished = 1'b1;
        seen_o   = o_vco1_fast_seen;
      end
    end
    i_vco1_fast = 1'b0; i_start = 1'b0;
    check_eq("run_reached_done", 32'(finished), 32'd1);
    repeat (3) tick();
    check_eq("run_idle_busy", 32'(o_busy), 32'd0);
    check_eq("run_idle_resetb", 32'(o_resetbAll), 32'd1);
    rst_low_n = rstb_low - r0;
    rise_n    = rises - s0;
    done_n    = done_cnt - d0;
    cap_o     = cap;
  endtask

  logic        seen;
  int          rl, rn, dn, viol, n, s0;
  logic [31:0] cp;

  initial begin
    tests_run = 0; tests_failed = 0;
    i_reset = 1'b1; i_start = 1'b0; i_cfg_gainA1 = '0; i_cfg_gainA2 = '0;
    i_ready = 1'b0; i_vco1_fast = 1'b0;
    repeat (3) tick();
    check_eq("reset_outputs", out_vec(), 32'd0);
    i_reset = 1'b0;

    // Idle after reset without start
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_resetbAll || o_sclk || o_busy || o_error) viol++;
    end
    check_eq("idle_no_start", 32'(viol), 32'd0);

    // Basic frame A1=101 A2=10
    do_run(3'b101, 2'b10, 1'b0, 1'b0, seen, rl, rn, dn, cp);
    check_eq("b0_resetb_low_cycles", 32'(rl), 32'd8);
    check_eq("b0_sclk_rises", 32'(rn), 32'(FW));
    check_eq("b0_frame", cp & FMASK, FRAME_B0);
    check_eq("b0_done_pulses", 32'(dn), 32'd1);
    check_eq("b0_no_error", 32'(o_error), 32'd0);

    // VCO flag pulsed mid-monitor, then held low
    do_run(3'b000, 2'b00, 1'b1, 1'b0, seen, rl, rn, dn, cp);
    check_eq("vco_seen_pulse", 32'(seen), 32'd1);
    check_eq("vco_resetb_low_rerun", 32'(rl), 32'd8);
    check_eq("vco_sticky_idle", 32'(o_vco1_fast_seen), 32'd1);
    do_run(3'b000, 2'b00, 1'b0, 1'b0, seen, rl, rn, dn, cp);
    check_eq("vco_seen_quiet", 32'(seen), 32'd0);

    // i_ready drops mid-shift
    s0 = rises;
    i_cfg_gainA1 = 3'b101; i_cfg_gainA2 = 2'b10; i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while ((rises - s0) < 2 && n < 200) begin tick(); n++; end
    check_eq("drop_reached_shift", 32'(n < 200), 32'd1);
    i_ready = 1'b0;
    tick();
    check_eq("drop_sclk_low", 32'(o_sclk), 32'd0);
    check_eq("drop_error", 32'(o_error), 32'd1);
    check_eq("drop_busy", 32'(o_busy), 32'd0);
    repeat (2) tick();
    check_eq("drop_error_sticky", 32'(o_error), 32'd1);

    // Ready never arrives
    s0 = rises;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("to_error_cleared", 32'(o_error), 32'd0);
    n = 1;
    while (!o_error && n < 200) begin tick(); n++; end
    check_eq("to_error_latency", 32'(n), 32'd73);
    check_eq("to_busy_low", 32'(o_busy), 32'd0);
    check_eq("to_no_sclk", 32'(rises - s0), 32'd0);
    tick();
    check_eq("to_error_sticky", 32'(o_error), 32'd1);

    // Reset during bit 4 of shift
    s0 = rises;
    i_cfg_gainA1 = 3'b101; i_cfg_gainA2 = 2'b10; i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while ((rises - s0) < 4 && n < 200) begin tick(); n++; end
    check_eq("rst_reached_bit4", 32'(n < 200), 32'd1);
    i_reset = 1'b1;
    tick();
    check_eq("rst_mid_shift_outputs", out_vec(), 32'd0);
    i_reset = 1'b0;
    tick();
    do_run(3'b011, 2'b01, 1'b0, 1'b1, seen, rl, rn, dn, cp);
    check_eq("rst_rerun_rises", 32'(rn), 32'(FW));
    check_eq("rst_rerun_frame", cp & FMASK, FRAME_68);
    check_eq("rst_rerun_done", 32'(dn), 32'd1);

    // Frame with A1=110 A2=11
    do_run(3'b110, 2'b11, 1'b0, 1'b0, seen, rl, rn, dn, cp);
    check_eq("d8_frame", cp & FMASK, FRAME_D8);
    check_eq("d8_rises", 32'(rn), 32'(FW));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
